// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer
// Multi-cycle multiply/divide unit that owns the architectural HI/LO
// registers. MULT/MULTU run a WIDTH-step shift-add multiply, DIV/DIVU run a
// WIDTH-step restoring divide on magnitudes, and a final FIX state applies
// sign correction and commits HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request strobe, sampled on a clk edge while idle
//   op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b         rs / rt operand values
//   flush        synchronous cancel of an in-flight operation
//   busy         high while an operation is in progress
//   done         one-cycle pulse when HI/LO show a new mult/div result
//   div_by_zero  one-cycle pulse with done when the divisor was zero
//   hi, lo       HI/LO registers
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for a request; MTHI/MTLO handled here
// S_MUL  | one shift-add step per cycle, WIDTH steps
// S_DIV  | one restoring divide step per cycle, WIDTH steps
// S_FIX  | sign correction and HI/LO commit (zero divide waits one extra cycle)
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;     // mult: product/multiplier; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;    // multiplicand or divisor magnitude
  logic               is_mul;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;

  logic               op_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != S_IDLE);

  // op[0] clear selects the signed variant for both MULT and DIV
  assign op_signed = ~op[0];
  assign abs_a = (op_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b = (op_signed && b[WIDTH-1]) ? -b : b;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right (carry in).
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: shift {rem, quo} left by one, trial-subtract the divisor.
  // The borrow bit of the W+1-bit difference decides keep vs restore.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      count       <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_mul      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              3'b000, 3'b001: begin
                acc    <= {{WIDTH{1'b0}}, abs_b};
                opnd   <= abs_a;
                is_mul <= 1'b1;
                neg_q  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= op_signed & a[WIDTH-1];
                dbz    <= 1'b0;
                count  <= '0;
                state  <= S_MUL;
              end
              3'b010, 3'b011: begin
                is_mul <= 1'b0;
                neg_q  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= op_signed & a[WIDTH-1];
                count  <= '0;
                opnd   <= abs_b;
                if (b == '0) begin
                  // raw dividend kept so FIX can return it in HI
                  acc   <= {{WIDTH{1'b0}}, a};
                  dbz   <= 1'b1;
                  state <= S_FIX;
                end else begin
                  acc   <= {{WIDTH{1'b0}}, abs_a};
                  dbz   <= 1'b0;
                  state <= S_DIV;
                end
              end
              3'b100:  hi <= a;
              3'b101:  lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc   <= mul_next;
            count <= count + 1'b1;
            if (count == LAST) state <= S_FIX;
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc   <= div_next;
            count <= count + 1'b1;
            if (count == LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (dbz && count == '0) begin
            // zero divide holds FIX one extra cycle so it commits two edges after start
            count <= CW'(1);
          end else begin
            if (dbz) begin
              hi          <= acc[WIDTH-1:0];
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else if (is_mul) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Scoreboard bench for hilo_muldiv_sequencer: the driver pushes reference
// results (computed with plain 64-bit arithmetic) and the expected commit
// cycle; a monitor pops and compares whenever done is seen.
module tb_hilo_muldiv_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_ex;
  int          cyc;
  int          vectors;
  int          miscompares;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input int e);
    exp_t        r;
    longint      sp;
    longint      sq;
    longint      sr;
    logic [63:0] v;
    logic [63:0] w;
    r.dbz = 1'b0;
    r.cyc = e + 33;
    r.hi  = '0;
    r.lo  = '0;
    case (o)
      3'b000: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        v = sp;
        r.hi = v[63:32];
        r.lo = v[31:0];
      end
      3'b001: begin
        v = {32'd0, x} * {32'd0, y};
        r.hi = v[63:32];
        r.lo = v[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          r.dbz = 1'b1;
          r.cyc = e + 2;
          r.hi  = x;
          r.lo  = 32'hFFFF_FFFF;
        end else if (o == 3'b010) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          v = sq;
          w = sr;
          r.lo = v[31:0];
          r.hi = w[31:0];
        end else begin
          r.lo = x / y;
          r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, guard);
    end
  endtask

  // Issues one request; pushes a scoreboard entry only when a result is owed.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit owed);
    exp_t ex;
    wait_idle();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (o[2] == 1'b0) begin
      check("busy_after_start", {31'd0, busy}, 32'd1);
      if (owed) begin
        ex = model(o, x, y, cyc);
        sb.push_back(ex);
        m_hi = ex.hi;
        m_lo = ex.lo;
      end
    end else if (o == 3'b100) begin
      m_hi = x;
      check("mthi_hi", hi, m_hi);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      check("mthi_done", {31'd0, done}, 32'd0);
    end else if (o == 3'b101) begin
      m_lo = x;
      check("mtlo_lo", lo, m_lo);
      check("mtlo_busy", {31'd0, busy}, 32'd0);
    end else begin
      check("reserved_busy", {31'd0, busy}, 32'd0);
      check("reserved_hi", hi, m_hi);
      check("reserved_lo", lo, m_lo);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, expected none", cyc);
        end else begin
          mon_ex = sb.pop_front();
          check("result_hi", hi, mon_ex.hi);
          check("result_lo", lo, mon_ex.lo);
          check("result_dbz", {31'd0, div_by_zero}, {31'd0, mon_ex.dbz});
          check("done_cycle", cyc, mon_ex.cyc);
          check("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end else if (div_by_zero) begin
        vectors++;
        miscompares++;
        $display("FAIL dbz_without_done: div_by_zero=1 done=0 expected 0");
      end
    end
  end

  initial begin
    int guard;
    vectors     = 0;
    miscompares = 0;
    m_hi        = '0;
    m_lo        = '0;
    reset_n     = 1'b0;
    start       = 1'b0;
    flush       = 1'b0;
    op          = 3'b000;
    a           = '0;
    b           = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;

    // directed vectors
    issue(3'b000, 32'hFFFF_FFFD, 32'd5, 1'b1);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'b011, 32'h0000_1234, 32'd0, 1'b1);
    issue(3'b100, 32'hA5A5_A5A5, 32'd0, 1'b0);
    issue(3'b101, 32'h5A5A_0001, 32'd0, 1'b0);
    issue(3'b110, 32'h1111_1111, 32'd3, 1'b0);

    // second start 10 cycles into a MULT must be dropped
    issue(3'b000, 32'd1234, 32'd5678, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 3'b011;
    a     = 32'd99;
    b     = 32'd0;
    @(negedge clk);
    start = 1'b0;

    // flush together with start in IDLE: request dropped
    wait_idle();
    start = 1'b1;
    flush = 1'b1;
    op    = 3'b000;
    a     = 32'd7;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    // flush mid-MULT: busy drops, hi/lo untouched, no done
    issue(3'b000, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);
    repeat (40) @(negedge clk);

    // reset mid-MULT
    issue(3'b001, 32'hCAFE_F00D, 32'h1357_9BDF, 1'b0);
    repeat (11) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic, back-to-back where busy allows
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 6)), pick(), pick(), 1'b1);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (40) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
Multi-cycle multiply/divide controller that owns the architectural HI/LO registers of the multi-cycle MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the control unit and runs a 32-iteration shift-add multiply or restoring divide. It asserts busy so the control FSM stalls MFHI/MFLO and any new mult/div until the result is committed. It replaces the single-cycle 64-bit multiply/divide path in the ALU.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request strobe, sampled on a clk edge
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored)
a  input  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
b  input  WIDTH  rt value (multiplier / divisor)
flush  input  1  synchronous cancel of an in-flight operation
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse on the cycle HI/LO show a new mult/div result
div_by_zero  output  1  one-cycle pulse coincident with done when a divide had b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: async on reset_n low. State IDLE; hi, lo, counter, internal accumulators = 0; busy = done = div_by_zero = 0.
- States: IDLE, MUL, DIV, FIX.
- busy = (state != IDLE), decoded combinationally from the state register.
- IDLE:
  - start with op MULT/MULTU/DIV/DIVU: latch operands. Signed ops store |a| and |b| as unsigned WIDTH-bit magnitudes (|0x80000000| = 0x80000000), plus the quotient/product sign (a[31]^b[31]) and the remainder sign (a[31]). Counter = 0. Next state MUL or DIV.
  - DIV/DIVU with b==0: go directly to FIX with the zero-divide flag set.
  - start with MTHI/MTLO: hi or lo <= a at the sampling edge. State stays IDLE; no busy, no done.
  - Reserved op: ignored.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator. The counter increments each cycle. After the step with counter == WIDTH-1, go to FIX.
- DIV: one restoring step per cycle: shift remainder:quotient left, trial subtract divisor, keep or restore, set quotient bit. After WIDTH steps, go to FIX.
- FIX:
  - Apply sign correction for signed ops. Product negated as 2*WIDTH two's complement. Quotient negated if signs differ. Remainder takes the dividend sign.
  - Write hi/lo. Mult: hi = product[63:32], lo = product[31:0]. Div: lo = quotient, hi = remainder.
  - Zero divisor: hi = a, lo = all ones, div_by_zero pulses.
  - Return to IDLE.
- done and div_by_zero are registered. They are high exactly in the first cycle after the FIX→IDLE edge, which is the same cycle busy is low and hi/lo hold the new values.
- Latency, with start sampled at edge E:
  - Normal mult/div: hi/lo updated at edge E+33, done high during cycle E+33..E+34.
  - Zero divide: updated at E+2.
- start while busy: ignored (no queueing). The control FSM holds the request until busy is low.
- start and done in the same cycle: accepted, since state is IDLE.
- flush: when busy, next state IDLE. hi/lo unchanged, no done. flush in IDLE has no effect. flush together with start in IDLE: flush wins, request dropped.
- INT_MIN / -1 (DIV): lo = 0x80000000, hi = 0 (wraps, no trap).
- reset_n asserted mid-operation: immediate abort, hi/lo cleared to 0.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 -> busy 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at E+33; signed MULT of same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done and div_by_zero at E+2; hi=0x1234, lo=0xFFFFFFFF; busy for 2 cycles.
- MTHI a=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next edge, busy/done stay 0. Then a second start during a MULT 10 cycles in -> ignored; result matches the first op only.
- MULT in flight:
  - flush at cycle 5 -> busy drops next cycle, hi/lo retain prior values, no done.
  - Separate run: reset_n low at cycle 12 -> hi=lo=0, busy=0 immediately.
